// File: rtl/updown_counter_mod.sv
// Parametrised up/down counter with programmable modulus, parallel load, clear,
// terminal-count decode and wrap pulse. Define UPDOWN_CNT_SAT_EN for saturating mode.
module updown_counter_mod #(
    parameter int WIDTH   = 8,
    parameter int MODULUS = 256
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_down,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count_out,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            // With MODULUS == 2**WIDTH, MAX_VAL is all ones and the clamp never fires.
            count_d = (load_value > MAX_VAL) ? MAX_VAL : load_value;
        end else if (enable) begin
            if (up_down) begin
                if (count_q == MAX_VAL) begin
                    wrap_d = 1'b1;
`ifdef UPDOWN_CNT_SAT_EN
                    count_d = MAX_VAL;
`else
                    count_d = '0;
`endif
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else begin
                if (count_q == '0) begin
                    wrap_d = 1'b1;
`ifdef UPDOWN_CNT_SAT_EN
                    count_d = '0;
`else
                    count_d = MAX_VAL;
`endif
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, and both are cleared asynchronously by reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count_out = count_q;
    assign wrap      = wrap_q;
    assign tc        = up_down ? (count_q == MAX_VAL) : (count_q == '0);

endmodule

// File: tb/tb_updown_counter_mod.sv
// Self-checking bench for updown_counter_mod (WIDTH=4, MODULUS=10): integer reference
// model compared every cycle plus hand-computed directed expectations.
module tb_updown_counter_mod;

    localparam int W = 4;
    localparam int M = 10;

    logic         clock;
    logic         reset;
    logic         enable;
    logic         up_down;
    logic         clear;
    logic         load;
    logic [W-1:0] load_value;
    logic [W-1:0] count_out;
    logic         tc;
    logic         wrap;

    int passed = 0;
    int total  = 0;

    int m_cnt  = 0;
    int m_wrap = 0;

`ifdef UPDOWN_CNT_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    updown_counter_mod #(.WIDTH(W), .MODULUS(M)) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .up_down    (up_down),
        .clear      (clear),
        .load       (load),
        .load_value (load_value),
        .count_out  (count_out),
        .tc         (tc),
        .wrap       (wrap)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference model: plain integer arithmetic with modulo/saturation rules.
    always @(posedge clock or negedge reset) begin
        int nxt;
        if (!reset) begin
            m_cnt  = 0;
            m_wrap = 0;
        end else begin
            m_wrap = 0;
            if (clear) begin
                m_cnt = 0;
            end else if (load) begin
                m_cnt = (int'(load_value) >= M) ? M - 1 : int'(load_value);
            end else if (enable) begin
                nxt = up_down ? m_cnt + 1 : m_cnt - 1;
                if (nxt >= M) begin
                    m_wrap = 1;
                    nxt = SAT ? M - 1 : nxt - M;
                end else if (nxt < 0) begin
                    m_wrap = 1;
                    nxt = SAT ? 0 : nxt + M;
                end
                m_cnt = nxt;
            end
        end
    end

    // Every-cycle comparison on the inactive edge.
    always @(negedge clock) begin
        check("model_count", int'(count_out), m_cnt);
        check("model_wrap", int'(wrap), m_wrap);
        check("model_tc", int'(tc), up_down ? int'(m_cnt == M - 1) : int'(m_cnt == 0));
    end

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; enable = 1'b0; up_down = 1'b1; clear = 1'b0;
        load = 1'b0; load_value = '0;
        #12;
        check("reset_count", int'(count_out), 0);
        check("reset_wrap", int'(wrap), 0);
        @(negedge clock);
        reset = 1'b1;

        // Count to 5, then asynchronous reset with no clock edge.
        enable = 1'b1; up_down = 1'b1;
        step(5);
        check("pre_reset_5", int'(count_out), 5);
        #2 reset = 1'b0;
        #1;
        check("async_reset_count", int'(count_out), 0);
        check("async_reset_wrap", int'(wrap), 0);
        reset = 1'b1;
        step(); check("post_reset_1", int'(count_out), 1);
        step(); check("post_reset_2", int'(count_out), 2);
        step(); check("post_reset_3", int'(count_out), 3);

        // Up wrap through 9 -> 0.
        clear = 1'b1; step(); clear = 1'b0;
        check("clear_0", int'(count_out), 0);
        step(9);
        check("up_at_9", int'(count_out), 9);
        check("up_tc_9", int'(tc), 1);
        check("up_wrap_9", int'(wrap), 0);
        step();
        check("up_wrap_to_0", int'(count_out), 0);
        check("up_wrap_pulse", int'(wrap), 1);
        step();
        check("up_after_wrap", int'(count_out), 1);
        check("up_wrap_gone", int'(wrap), 0);

        // Down wrap from 1.
        enable = 1'b0; load = 1'b1; load_value = 4'd1; step(); load = 1'b0;
        enable = 1'b1; up_down = 1'b0;
        #1 check("down_tc_1", int'(tc), 0);
        step(); check("down_0", int'(count_out), 0);
        check("down_tc_0", int'(tc), 1);
        step(); check("down_9", int'(count_out), 9);
        check("down_wrap_pulse", int'(wrap), 1);
        step(); check("down_8", int'(count_out), 8);
        check("down_wrap_gone", int'(wrap), 0);

        // Priority clear > load > enable, and load clamp.
        load = 1'b1; load_value = 4'd4; step();
        check("load_4", int'(count_out), 4);
        clear = 1'b1; load_value = 4'd7; step();
        check("clear_beats_load", int'(count_out), 0);
        clear = 1'b0; step();
        check("load_beats_enable", int'(count_out), 7);
        load_value = 4'd12; step();
        check("load_clamp", int'(count_out), 9);
        load_value = 4'd15; step();
        check("load_clamp_15", int'(count_out), 9);

        // Hold and direction toggling.
        load_value = 4'd6; enable = 1'b0; step(); load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_6", int'(count_out), 6);
            check("hold_wrap", int'(wrap), 0);
        end
        enable = 1'b1;
        up_down = 1'b1; step(); check("toggle_7a", int'(count_out), 7);
        up_down = 1'b0; step(); check("toggle_6", int'(count_out), 6);
        up_down = 1'b1; step(); check("toggle_7b", int'(count_out), 7);

        // Limit behaviour going up from 8 and down from 1.
        enable = 1'b0; load = 1'b1; load_value = 4'd8; step(); load = 1'b0;
        enable = 1'b1; up_down = 1'b1;
        step(); check("lim_up_1", int'(count_out), 9); check("lim_up_w1", int'(wrap), 0);
        step(); check("lim_up_2", int'(count_out), SAT ? 9 : 0); check("lim_up_w2", int'(wrap), 1);
        step(); check("lim_up_3", int'(count_out), SAT ? 9 : 1); check("lim_up_w3", int'(wrap), SAT ? 1 : 0);
        enable = 1'b0; load = 1'b1; load_value = 4'd1; step(); load = 1'b0;
        enable = 1'b1; up_down = 1'b0;
        step(); check("lim_dn_1", int'(count_out), 0); check("lim_dn_w1", int'(wrap), 0);
        step(); check("lim_dn_2", int'(count_out), SAT ? 0 : 9); check("lim_dn_w2", int'(wrap), 1);
        step(); check("lim_dn_3", int'(count_out), SAT ? 0 : 8); check("lim_dn_w3", int'(wrap), SAT ? 1 : 0);

        enable = 1'b0;
        step(2);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
